alu_issue_wb: RTL and testbench

//  Execute/writeback stage wrapped around the 8-bit combinational ALU.

---
 rtl/alu_issue_wb.sv | 133 +++++++++++++
 tb/tb_alu_issue_wb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
// alu_issue_wb -- execute/writeback stage wrapped around an external 8-bit
// combinational ALU.
//
// An instruction is accepted over in_valid/in_ready. Its operands are read
// from a small local register file, or forwarded from the ALU when the
// instruction ahead is retiring on the same edge. They are held in the EX
// register, which drives the ALU. The ALU result is written back to the
// register file and, on the same edge, captured into the OUT register. OUT
// is presented downstream over out_valid/out_ready.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           instruction handshake
//   in_op/in_rd/in_rs1/in_rs2   opcode and register indices
//   in_imm                      immediate (load-imm only)
//   alu_a/alu_b/alu_op          ALU operands and opcode (EX register)
//   alu_result                  ALU combinational result
//   out_valid/out_ready         result handshake
//   out_data/out_rd/out_zero    result, destination, zero flag
module alu_issue_wb #(
   parameter int W    = 8,
   parameter int NREG = 4,
   parameter int AW   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs1,
   input  logic [AW-1:0] in_rs2,
   input  logic [W-1:0]  in_imm,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [2:0]    alu_op,
   input  logic [W-1:0]  alu_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [AW-1:0] out_rd,
   output logic          out_zero
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LI  = 3'b010;

   typedef struct packed {
      logic [2:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [AW-1:0] rd;
   } ex_t;

   logic [NREG-1:0][W-1:0] rf;
   logic                   ex_valid;
   ex_t                    ex;
   logic                   ex_fire;
   logic                   accept;
   logic [W-1:0]           rs1_val;
   logic [W-1:0]           rs2_val;

   // EX retires whenever OUT is empty or is being drained this cycle.
   assign ex_fire  = ex_valid & (~out_valid | out_ready);
   assign in_ready = ~ex_valid | ex_fire;
   assign accept   = in_valid & in_ready;

   assign alu_a  = ex.a;
   assign alu_b  = ex.b;
   assign alu_op = ex.op;

   // The register file write for the retiring instruction lands on the same
   // edge as the read of the next one. A RAW hazard on ex.rd must therefore
   // take the ALU output directly.
   always_comb begin
      rs1_val = rf[in_rs1];
      rs2_val = rf[in_rs2];
      if (ex_fire && in_rs1 == ex.rd) rs1_val = alu_result;
      if (ex_fire && in_rs2 == ex.rd) rs2_val = alu_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (ex_fire) begin
         rf[ex.rd] <= alu_result;
      end
   end

   // EX stage. An accept on the same edge as ex_fire refills EX, so
   // ex_valid stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex       <= '0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ex.rd    <= in_rd;
         if (in_op == OP_LI) begin
            // load-imm is executed as imm + 0.
            ex.op <= OP_ADD;
            ex.a  <= in_imm;
            ex.b  <= '0;
         end else begin
            // Reserved opcodes pass through. The ALU yields 0 for them,
            // and that 0 is written back like any other result.
            ex.op <= in_op;
            ex.a  <= rs1_val;
            ex.b  <= rs2_val;
         end
      end else if (ex_fire) begin
         ex_valid <= 1'b0;
      end
   end

   // OUT stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_rd    <= '0;
         out_zero  <= 1'b0;
      end else if (ex_fire) begin
         out_valid <= 1'b1;
         out_data  <= alu_result;
         out_rd    <= ex.rd;
         out_zero  <= (alu_result == '0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_wb.sv
module tb_alu_issue_wb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [1:0] in_rd, in_rs1, in_rs2;
   logic [7:0] in_imm;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_rd;
   logic       out_zero;

   int checks   = 0;
   int failures = 0;
   bit rnd_done;

   always #5 clk = ~clk;

   alu_issue_wb #(.W(8), .NREG(4), .AW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .out_zero(out_zero)
   );

   // External combinational ALU
   always_comb begin
      case (alu_op)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b011:  alu_result = alu_a << alu_b[2:0];
         3'b100:  alu_result = alu_a >> alu_b[2:0];
         3'b101:  alu_result = $unsigned($signed(alu_a) >>> alu_b[2:0]);
         default: alu_result = 8'h00;
      endcase
   end

   // Reference model: instructions executed sequentially in program order
   // at acceptance time; expected results queued for the output stream.
   typedef struct {logic [1:0] rd; logic [7:0] data;} res_t;
   logic [7:0] rf_m [4];
   res_t       exp_q [$];
   int         n_xfer = 0;

   function automatic logic [7:0] ref_exec(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] imm);
      int sh;
      logic [7:0] r;
      sh = int'(b % 8);
      case (op)
         3'd0: r = 8'((int'(a) + int'(b)) % 256);
         3'd1: r = 8'((int'(a) - int'(b) + 256) % 256);
         3'd2: r = imm;
         3'd3: r = 8'((int'(a) * (1 << sh)) % 256);
         3'd4: r = 8'(int'(a) / (1 << sh));
         3'd5: r = 8'((int'($signed(a)) >>> sh) & 255);
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            res_t e;
            n_xfer++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL stream_extra: got rd=%0d data=%h, expected nothing", out_rd, out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_rd, out_data, out_zero} !== {e.rd, e.data, e.data == 8'h00}) begin
                  failures++;
                  $display("FAIL stream: got rd=%0d data=%h zero=%b, expected rd=%0d data=%h zero=%b",
                           out_rd, out_data, out_zero, e.rd, e.data, e.data == 8'h00);
               end
            end
         end
         if (in_valid && in_ready) begin
            res_t e;
            e.rd   = in_rd;
            e.data = ref_exec(in_op, rf_m[in_rs1], rf_m[in_rs2], in_imm);
            rf_m[in_rd] = e.data;
            exp_q.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm);
      bit acc = 0;
      int n = 0;
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         step();
         n++;
      end
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL issue_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      in_op = 3'b000; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0; in_imm = 8'h00;
      out_ready = 1'b1;
      rst_n = 1'b0;
      #2;
      checks++;
      if (alu_op !== 3'b000 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_during: alu_op=%b out_valid=%b, expected 000/0", alu_op, out_valid);
      end
      apply_reset();
      checks++;
      if ({out_valid, out_data, out_rd, out_zero} !== 12'h0) begin
         failures++;
         $display("FAIL reset_out: valid=%b data=%h rd=%0d zero=%b, expected all 0",
                  out_valid, out_data, out_rd, out_zero);
      end
      checks++;
      if ({alu_a, alu_b, alu_op} !== 19'h0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ex: a=%h b=%h op=%b in_ready=%b, expected 0/0/0/1",
                  alu_a, alu_b, alu_op, in_ready);
      end
   endtask

   // li r1,05; li r2,03; add r3,r1,r2 -> one result per cycle
   task automatic test_basic_stream();
      out_ready = 1'b1;
      issue(3'b010, 2'd1, 2'd0, 2'd0, 8'h05);
      issue(3'b010, 2'd2, 2'd0, 2'd0, 8'h03);
      issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00);
      checks++;
      if ({out_valid, out_rd, out_data} !== {1'b1, 2'd2, 8'h03}) begin
         failures++;
         $display("FAIL t1_second: valid=%b rd=%0d data=%h, expected 1/2/03", out_valid, out_rd, out_data);
      end
      step();
      checks++;
      if ({out_valid, out_rd, out_data} !== {1'b1, 2'd3, 8'h08}) begin
         failures++;
         $display("FAIL t1_third: valid=%b rd=%0d data=%h, expected 1/3/08", out_valid, out_rd, out_data);
      end
      step();
   endtask

   // li r0,03; sub r1,r0,r0 back to back
   task automatic test_back_to_back();
      issue(3'b010, 2'd0, 2'd0, 2'd0, 8'h03);
      issue(3'b001, 2'd1, 2'd0, 2'd0, 8'h00);
      step();
      checks++;
      if ({out_rd, out_data, out_zero} !== {2'd1, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL t2_raw: rd=%0d data=%h zero=%b, expected 1/00/1", out_rd, out_data, out_zero);
      end
      step();
   endtask

   task automatic test_wrap_shift();
      issue(3'b010, 2'd1, 2'd0, 2'd0, 8'hFF);
      issue(3'b010, 2'd2, 2'd0, 2'd0, 8'h01);
      issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00);
      issue(3'b011, 2'd3, 2'd1, 2'd2, 8'h00);
      checks++;
      if ({out_rd, out_data, out_zero} !== {2'd3, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL t3_wrap: rd=%0d data=%h zero=%b, expected 3/00/1", out_rd, out_data, out_zero);
      end
      step();
      checks++;
      if ({out_rd, out_data, out_zero} !== {2'd3, 8'hFE, 1'b0}) begin
         failures++;
         $display("FAIL t3_shl: rd=%0d data=%h zero=%b, expected 3/FE/0", out_rd, out_data, out_zero);
      end
      step();
   endtask

   task automatic test_backpressure();
      int x0;
      out_ready = 1'b0;
      x0 = n_xfer;
      issue(3'b010, 2'd0, 2'd0, 2'd0, 8'h21);
      issue(3'b010, 2'd1, 2'd0, 2'd0, 8'h42);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({in_ready, out_valid, out_rd, out_data} !== {1'b0, 1'b1, 2'd0, 8'h21}) begin
            failures++;
            $display("FAIL t4_hold: cyc=%0d in_ready=%b valid=%b rd=%0d data=%h, expected 0/1/0/21",
                     i, in_ready, out_valid, out_rd, out_data);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if ({out_valid, out_rd, out_data} !== {1'b1, 2'd1, 8'h42}) begin
         failures++;
         $display("FAIL t4_second: valid=%b rd=%0d data=%h, expected 1/1/42", out_valid, out_rd, out_data);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || n_xfer - x0 != 2 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL t4_drain: valid=%b xfers=%0d pending=%0d, expected 0/2/0",
                  out_valid, n_xfer - x0, exp_q.size());
      end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      issue(3'b010, 2'd1, 2'd0, 2'd0, 8'h11);
      in_op = 3'b010; in_rd = 2'd2; in_imm = 8'h22;
      in_valid = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL t5_prereset: out_valid=%b, expected 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL t5_async: out_valid=%b, expected 0", out_valid);
      end
      in_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
      step();
      rst_n = 1'b1;
      step();
      issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00);
      step();
      checks++;
      if ({out_valid, out_rd, out_data, out_zero} !== {1'b1, 2'd3, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL t5_after: valid=%b rd=%0d data=%h zero=%b, expected 1/3/00/1",
                  out_valid, out_rd, out_data, out_zero);
      end
      step();
   endtask

   task automatic test_reserved();
      issue(3'b010, 2'd1, 2'd0, 2'd0, 8'h7A);
      issue(3'b110, 2'd2, 2'd1, 2'd1, 8'h00);
      step();
      checks++;
      if ({out_rd, out_data, out_zero} !== {2'd2, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL t6_reserved: rd=%0d data=%h zero=%b, expected 2/00/1", out_rd, out_data, out_zero);
      end
      issue(3'b000, 2'd3, 2'd2, 2'd1, 8'h00);
      step();
      checks++;
      if ({out_rd, out_data} !== {2'd3, 8'h7A}) begin
         failures++;
         $display("FAIL t6_writeback: rd=%0d data=%h, expected 3/7A", out_rd, out_data);
      end
      step();
   endtask

   task automatic test_random();
      int n;
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
               if ($urandom_range(0, 3) == 0) step();
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               step();
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step();
         n++;
      end
      step();
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL random_drain: pending=%0d out_valid=%b, expected 0/0", exp_q.size(), out_valid);
      end
   endtask

   initial begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
      test_reset();
      test_basic_stream();
      test_back_to_back();
      test_wrap_shift();
      test_backpressure();
      test_mid_reset();
      test_reserved();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
